// File: rtl/can_bit_timing.sv
// CAN bit-timing stage: synchronizes the bus pin, divides the clock into time quanta and
// tracks bit position with hard sync / resync, producing the sample-point strobe.
module can_bit_timing #(
    parameter int unsigned N_BRP   = 4,
    parameter int unsigned N_TSEG1 = 11,
    parameter int unsigned N_TSEG2 = 4,
    parameter int unsigned N_SJW   = 4,
    parameter int unsigned D_BRP   = 1,
    parameter int unsigned D_TSEG1 = 11,
    parameter int unsigned D_TSEG2 = 4,
    parameter int unsigned D_SJW   = 4
) (
    input  logic clock,
    input  logic resetN,
    input  logic canRX,
    input  logic busIdle,
    input  logic fdData,
    output logic samplePoint,
    output logic canRXsync,
    output logic bitStart,
    output logic hardSync,
    output logic dataPhase
);

    typedef enum logic [1:0] {StSync, StTseg1, StTseg2} state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev_sync;
    logic [7:0] r_tq_cnt;
    logic [6:0] r_seg_cnt;
    logic [4:0] r_ext;
    logic [4:0] r_cut;
    logic       r_sync_done;
    logic       r_last_sample;
    logic       r_data_phase;
    logic       r_bit_start;

    logic [7:0] w_brp_m1;
    logic [6:0] w_tseg1;
    logic [6:0] w_tseg2;
    logic [4:0] w_sjw;
    logic [6:0] w_tseg1_len;
    logic [6:0] w_tseg2_len;
    logic [6:0] w_e;
    logic [6:0] w_rem;
    logic [4:0] w_ext_new;
    logic [4:0] w_cut_eff;
    logic       w_tq_tick;
    logic       w_edge;
    logic       w_hard_sync;
    logic       w_resync;
    logic       w_resync_t1;
    logic       w_resync_t2;
    logic       w_early_end;
    logic       w_cut_set;
    logic       w_sample;
    logic       w_tseg2_end;
    logic       w_seg_done;
    logic       w_restart;
    logic       w_enter_sync;

    assign w_brp_m1 = r_data_phase ? 8'(D_BRP - 1) : 8'(N_BRP - 1);
    assign w_tseg1  = r_data_phase ? 7'(D_TSEG1)   : 7'(N_TSEG1);
    assign w_tseg2  = r_data_phase ? 7'(D_TSEG2)   : 7'(N_TSEG2);
    assign w_sjw    = r_data_phase ? 5'(D_SJW)     : 5'(N_SJW);

    assign w_tq_tick   = (r_tq_cnt == w_brp_m1);
    assign w_edge      = r_prev_sync & ~r_sync2;
    assign w_hard_sync = w_edge & busIdle;
    assign w_resync    = w_edge & ~busIdle & r_last_sample & ~r_sync_done;
    assign w_resync_t1 = w_resync & (r_state == StTseg1);
    assign w_resync_t2 = w_resync & (r_state == StTseg2);

    assign w_e         = r_seg_cnt + 7'd1;
    assign w_ext_new   = (w_e > 7'(w_sjw)) ? w_sjw : 5'(w_e);
    assign w_rem       = w_tseg2 - r_seg_cnt;
    assign w_early_end = w_resync_t2 & (w_rem <= 7'(w_sjw));
    assign w_cut_set   = w_resync_t2 & ~w_early_end;
    // A cut taken on a TQ's last clock must shorten the segment in that same clock.
    assign w_cut_eff   = w_cut_set ? w_sjw : r_cut;

    assign w_tseg1_len  = w_tseg1 + 7'(r_ext);
    assign w_tseg2_len  = w_tseg2 - 7'(w_cut_eff);
    assign w_sample     = (r_state == StTseg1) & w_tq_tick & (r_seg_cnt == w_tseg1_len - 7'd1);
    assign w_tseg2_end  = (r_state == StTseg2) & w_tq_tick & (r_seg_cnt == w_tseg2_len - 7'd1);
    assign w_seg_done   = ((r_state == StSync) & w_tq_tick) | w_sample | w_tseg2_end;
    assign w_restart    = w_hard_sync | w_early_end;
    assign w_enter_sync = w_restart | w_tseg2_end;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= StSync;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StSync:  if (w_tq_tick)   w_state_next = StTseg1;
            StTseg1: if (w_sample)    w_state_next = StTseg2;
            StTseg2: if (w_tseg2_end) w_state_next = StSync;
            default: w_state_next = StSync;
        endcase
        if (w_restart) begin
            w_state_next = StSync;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_prev_sync   <= 1'b1;
            r_tq_cnt      <= '0;
            r_seg_cnt     <= '0;
            r_ext         <= '0;
            r_cut         <= '0;
            r_sync_done   <= 1'b0;
            r_last_sample <= 1'b1;
            r_data_phase  <= 1'b0;
            r_bit_start   <= 1'b0;
        end else begin
            r_sync1     <= canRX;
            r_sync2     <= r_sync1;
            r_prev_sync <= r_sync2;
            r_bit_start <= w_enter_sync;

            if (w_restart || w_tq_tick) begin
                r_tq_cnt <= '0;
            end else begin
                r_tq_cnt <= r_tq_cnt + 8'd1;
            end

            if (w_restart || w_seg_done) begin
                r_seg_cnt <= '0;
            end else if (w_tq_tick) begin
                r_seg_cnt <= r_seg_cnt + 7'd1;
            end

            if (w_enter_sync) begin
                r_ext <= '0;
                r_cut <= '0;
            end else begin
                if (w_resync_t1) r_ext <= w_ext_new;
                if (w_cut_set)   r_cut <= w_sjw;
            end

            if (w_sample) begin
                r_last_sample <= r_sync2;
                r_sync_done   <= 1'b0;
            end
            if (w_hard_sync || w_resync_t1 || w_resync_t2) begin
                r_sync_done <= 1'b1;
            end

            if (w_hard_sync) begin
                r_data_phase <= 1'b0;
            end else if (w_sample) begin
                r_data_phase <= fdData;
            end
        end
    end

    always_comb begin
        samplePoint = w_sample;
        canRXsync   = r_sync2;
        bitStart    = r_bit_start;
        hardSync    = w_hard_sync;
        dataPhase   = r_data_phase;
    end

endmodule

// File: tb/tb_can_bit_timing.sv
// Directed bench for can_bit_timing: table of single-bit scenarios plus reset and FD
// switching sequences; a second instance runs with SJW=2.
module tb_can_bit_timing;

    logic clock = 1'b0;
    logic resetN;
    logic canRX;
    logic busIdle;
    logic fdData;
    logic sp_a, rx_a, bs_a, hs_a, dp_a;
    logic sp_b, rx_b, bs_b, hs_b, dp_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    can_bit_timing u_dut (
        .clock(clock), .resetN(resetN), .canRX(canRX), .busIdle(busIdle), .fdData(fdData),
        .samplePoint(sp_a), .canRXsync(rx_a), .bitStart(bs_a), .hardSync(hs_a),
        .dataPhase(dp_a)
    );

    can_bit_timing #(.N_SJW(2)) u_dut_sjw2 (
        .clock(clock), .resetN(resetN), .canRX(canRX), .busIdle(busIdle), .fdData(fdData),
        .samplePoint(sp_b), .canRXsync(rx_b), .bitStart(bs_b), .hardSync(hs_b),
        .dataPhase(dp_b)
    );

    typedef struct {
        bit sel;
        bit idle;
        bit fd;
        int t1;
        int t2;
        int exp_hs;
        int exp_sp;
        int exp_bs;
        bit exp_dp;
    } vec_t;

    vec_t vecs [13];

    function automatic logic sp_of(input bit sel);
        return sel ? sp_b : sp_a;
    endfunction
    function automatic logic bs_of(input bit sel);
        return sel ? bs_b : bs_a;
    endfunction
    function automatic logic hs_of(input bit sel);
        return sel ? hs_b : hs_a;
    endfunction
    function automatic logic dp_of(input bit sel);
        return sel ? dp_b : dp_a;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        canRX  = 1'b1;
        repeat (3) @(negedge clock);
        resetN = 1'b1;
    endtask

    task automatic wait_bs(input bit sel, output int found);
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(negedge clock);
            if (bs_of(sel)) found = 1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int f_sp, f_bs, f_hs, dp48;
        int sp_at [4];
        int bs_at [4];
        int ns, nb, dp80;

        vecs[0]  = '{0, 0, 0,  0,  0, -1, 47, 64, 0};
        vecs[1]  = '{0, 0, 0, 13,  0, -1, 59, 76, 0};
        vecs[2]  = '{0, 0, 0, 13, 33, -1, 59, 76, 0};
        vecs[3]  = '{0, 0, 0, 44,  0, -1, 63, 80, 0};
        vecs[4]  = '{0, 0, 0, 48,  0, -1, 47, 49, 0};
        vecs[5]  = '{0, 0, 0, 60,  0, -1, 47, 61, 0};
        vecs[6]  = '{1, 0, 0, 48,  0, -1, 47, 56, 0};
        vecs[7]  = '{1, 0, 0, 13,  0, -1, 55, 72, 0};
        vecs[8]  = '{0, 1, 0, 30,  0, 30, 78, 31, 0};
        vecs[9]  = '{0, 0, 0,  2,  0, -1, 47, 64, 0};
        vecs[10] = '{0, 0, 0, 47,  0, -1, 47, 64, 0};
        vecs[11] = '{0, 1, 1, 47,  0, 47, 47, 48, 0};
        vecs[12] = '{0, 0, 1,  0,  0, -1, 47, 52, 1};

        // Reset values, with the pin dominant and FD requested so they are not trivial.
        resetN  = 1'b0;
        canRX   = 1'b0;
        busIdle = 1'b0;
        fdData  = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_samplePoint", sp_a, 0);
        check("rst_bitStart", bs_a, 0);
        check("rst_hardSync", hs_a, 0);
        check("rst_dataPhase", dp_a, 0);
        check("rst_canRXsync", rx_a, 1);

        canRX  = 1'b1;
        fdData = 1'b0;
        resetN = 1'b1;
        f_sp = -1;
        f_bs = -1;
        for (int off = 0; off <= 140; off++) begin
            if (off > 0) @(negedge clock);
            if (sp_a && f_sp < 0) f_sp = off;
            if (bs_a && f_bs < 0) f_bs = off;
            if (rx_a !== 1'b1) check("freerun_canRXsync", rx_a, 1);
        end
        check("release_no_early_bitStart", int'(f_bs >= 2), 1);
        check("release_sp_to_bs", f_bs - f_sp, 17);

        foreach (vecs[i]) begin
            busIdle = vecs[i].idle;
            fdData  = 1'b0;
            do_reset();
            wait_bs(vecs[i].sel, found);
            check($sformatf("v%0d_bitStart_found", i), found, 1);
            f_sp = -1;
            f_bs = -1;
            f_hs = -1;
            dp48 = -1;
            for (int off = 0; off <= 140; off++) begin
                if (off > 0) @(negedge clock);
                if (sp_of(vecs[i].sel) && f_sp < 0) f_sp = off;
                if (off > 0 && bs_of(vecs[i].sel) && f_bs < 0) f_bs = off;
                if (hs_of(vecs[i].sel) && f_hs < 0) f_hs = off;
                if (off == 48) dp48 = int'(dp_of(vecs[i].sel));
                if (off == 10) fdData = vecs[i].fd;
                if (vecs[i].t1 >= 2 && off == vecs[i].t1 - 2) canRX = 1'b0;
                if (vecs[i].t2 > 0 && off == vecs[i].t2 - 8) canRX = 1'b1;
                if (vecs[i].t2 > 0 && off == vecs[i].t2 - 2) canRX = 1'b0;
            end
            check($sformatf("v%0d_hardSync_at", i), f_hs, vecs[i].exp_hs);
            check($sformatf("v%0d_samplePoint_at", i), f_sp, vecs[i].exp_sp);
            check($sformatf("v%0d_bitStart_at", i), f_bs, vecs[i].exp_bs);
            check($sformatf("v%0d_dataPhase_48", i), dp48, int'(vecs[i].exp_dp));
        end

        // FD switch in, data bits, then back to nominal.
        busIdle = 1'b0;
        fdData  = 1'b0;
        do_reset();
        wait_bs(0, found);
        check("fd_bitStart_found", found, 1);
        for (int k = 0; k < 4; k++) begin
            sp_at[k] = -1;
            bs_at[k] = -1;
        end
        ns = 0;
        nb = 0;
        dp48 = -1;
        dp80 = -1;
        for (int off = 0; off <= 150; off++) begin
            if (off > 0) @(negedge clock);
            if (sp_a && ns < 4) begin
                sp_at[ns] = off;
                ns++;
            end
            if (off > 0 && bs_a && nb < 4) begin
                bs_at[nb] = off;
                nb++;
            end
            if (off == 48) dp48 = int'(dp_a);
            if (off == 80) dp80 = int'(dp_a);
            if (off == 10) fdData = 1'b1;
            if (off == 70) fdData = 1'b0;
        end
        check("fd_dataPhase_48", dp48, 1);
        check("fd_dataPhase_80", dp80, 0);
        check("fd_sp0", sp_at[0], 47);
        check("fd_sp1", sp_at[1], 63);
        check("fd_sp2", sp_at[2], 79);
        check("fd_sp3", sp_at[3], 143);
        check("fd_bs0", bs_at[0], 52);
        check("fd_bs1", bs_at[1], 68);
        check("fd_bs2", bs_at[2], 96);

        // Asynchronous reset in the middle of a data-phase TSEG1.
        do_reset();
        wait_bs(0, found);
        check("midrst_bitStart_found", found, 1);
        for (int off = 1; off <= 58; off++) begin
            @(negedge clock);
            if (off == 10) fdData = 1'b1;
            if (off == 54) canRX = 1'b0;
        end
        check("midrst_pre_dataPhase", dp_a, 1);
        check("midrst_pre_canRXsync", rx_a, 0);
        resetN = 1'b0;
        #1;
        check("midrst_dataPhase", dp_a, 0);
        check("midrst_canRXsync", rx_a, 1);
        check("midrst_samplePoint", sp_a, 0);
        check("midrst_bitStart", bs_a, 0);
        check("midrst_hardSync", hs_a, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (sp_a || bs_a || hs_a) check("midrst_no_pulse", 1, 0);
        end
        canRX  = 1'b1;
        fdData = 1'b0;
        resetN = 1'b1;
        wait_bs(0, found);
        check("midrst_first_bitStart", found, 1);
        f_sp = -1;
        for (int off = 1; off <= 100 && f_sp < 0; off++) begin
            @(negedge clock);
            if (sp_a) f_sp = off;
        end
        check("midrst_sp_after_bs", f_sp, 47);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
